// File: rtl/delay_arbiter_pkg.sv
// Shared definitions for the delay arbiter: op encoding, register map and STATUS layout.
package delay_arbiter_pkg;

   typedef enum logic [1:0] {
      OP_INC = 2'd0,
      OP_DEC = 2'd1,
      OP_SET = 2'd2
   } op_e;

   localparam logic [1:0] ADDR_DELAY  = 2'd0;
   localparam logic [1:0] ADDR_CMD    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_DROPS  = 2'd3;

   localparam int STAT_KEY_PEND   = 0;
   localparam int STAT_HOST_PEND  = 1;
   localparam int STAT_LAST_GRANT = 2;
   localparam int STAT_AT_MIN     = 3;
   localparam int STAT_AT_MAX     = 4;

endpackage

// File: rtl/delay_req_slot.sv
// One-entry pending op register for a single requester, with cancel, replace and drop reporting.
module delay_req_slot
   import delay_arbiter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             set_i,
   input  logic [WIDTH-1:0] set_val_i,
   input  logic             grant_i,
   output logic             pending_o,
   output op_e              op_o,
   output logic [WIDTH-1:0] val_o,
   output logic             drop_o
);

   logic             pending_q, pending_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic             new_op_s;

   // Capture, replace or clear the slot; inc and dec together cancel out
   always_comb begin
      new_op_s  = set_i | (inc_i ^ dec_i);
      pending_d = pending_q;
      op_d      = op_q;
      val_d     = val_q;
      drop_o    = 1'b0;
      if (new_op_s) begin
         pending_d = 1'b1;
         drop_o    = pending_q & ~grant_i;
         if (set_i) begin
            op_d  = OP_SET;
            val_d = set_val_i;
         end else if (inc_i) begin
            op_d  = OP_INC;
            val_d = val_q;
         end else begin
            op_d  = OP_DEC;
            val_d = val_q;
         end
      end else if (grant_i) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   // Slot state register
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= 1'b0;
         op_q      <= OP_INC;
         val_q     <= '0;
      end else begin
         pending_q <= pending_d;
         op_q      <= op_d;
         val_q     <= val_d;
      end
   end

   assign pending_o = pending_q;
   assign op_o      = op_q;
   assign val_o     = val_q;

endmodule

// File: rtl/delay_arbiter.sv
// Arbitrates key and host delay requests, owns the pause level and exposes an Avalon-MM register file.
module delay_arbiter
   import delay_arbiter_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int DELAY_MIN  = 0,
   parameter int DELAY_MAX  = 15,
   parameter int DELAY_INIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_slower,
   input  logic             key_faster,
   input  logic             key_pause,
   input  logic [1:0]       avs_address,
   input  logic             avs_write,
   input  logic [7:0]       avs_writedata,
   input  logic             avs_read,
   output logic [7:0]       avs_readdata,
   output logic [WIDTH-1:0] delay,
   output logic             pause
);

   localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(DELAY_MIN);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(DELAY_MAX);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(DELAY_INIT);

   logic [WIDTH-1:0] delay_q, delay_d;
   logic             pause_q, pause_d;
   logic             last_grant_q, last_grant_d;
   logic [7:0]       drops_q, drops_d;
   logic [7:0]       readdata_q, readdata_d;

   logic             host_set_s, host_cmd_s, host_inc_s, host_dec_s, host_pause_s;
   logic             key_pend_s, host_pend_s, key_grant_s, host_grant_s;
   logic             key_drop_s, host_drop_s;
   op_e              key_op_s, host_op_s, sel_op_s;
   logic [WIDTH-1:0] key_val_s, host_val_s, sel_val_s;
   logic             at_min_s, at_max_s;
   logic [7:0]       status_s;
   logic             unused_wdata_s;

   assign host_set_s   = avs_write & (avs_address == ADDR_DELAY);
   assign host_cmd_s   = avs_write & (avs_address == ADDR_CMD);
   assign host_inc_s   = host_cmd_s & avs_writedata[0];
   assign host_dec_s   = host_cmd_s & avs_writedata[1];
   assign host_pause_s = host_cmd_s & avs_writedata[2];
   assign unused_wdata_s = ^avs_writedata[7:3];

   delay_req_slot #(.WIDTH(WIDTH)) u_key_slot (
      .clk       (clk),
      .reset     (reset),
      .inc_i     (key_slower),
      .dec_i     (key_faster),
      .set_i     (1'b0),
      .set_val_i ({WIDTH{1'b0}}),
      .grant_i   (key_grant_s),
      .pending_o (key_pend_s),
      .op_o      (key_op_s),
      .val_o     (key_val_s),
      .drop_o    (key_drop_s)
   );

   delay_req_slot #(.WIDTH(WIDTH)) u_host_slot (
      .clk       (clk),
      .reset     (reset),
      .inc_i     (host_inc_s),
      .dec_i     (host_dec_s),
      .set_i     (host_set_s),
      .set_val_i (avs_writedata[WIDTH-1:0]),
      .grant_i   (host_grant_s),
      .pending_o (host_pend_s),
      .op_o      (host_op_s),
      .val_o     (host_val_s),
      .drop_o    (host_drop_s)
   );

   assign at_min_s = (delay_q == MIN_V);
   assign at_max_s = (delay_q == MAX_V);

   // Round-robin grant: on contention the requester that did not win last time goes first
   always_comb begin
      key_grant_s  = key_pend_s  & (~host_pend_s | last_grant_q);
      host_grant_s = host_pend_s & (~key_pend_s  | ~last_grant_q);
      if (key_grant_s) begin
         sel_op_s     = key_op_s;
         sel_val_s    = key_val_s;
         last_grant_d = 1'b0;
      end else if (host_grant_s) begin
         sel_op_s     = host_op_s;
         sel_val_s    = host_val_s;
         last_grant_d = 1'b1;
      end else begin
         sel_op_s     = key_op_s;
         sel_val_s    = key_val_s;
         last_grant_d = last_grant_q;
      end
   end

   // Saturating delay update from the granted op
   always_comb begin
      delay_d = delay_q;
      if (key_grant_s | host_grant_s) begin
         case (sel_op_s)
            OP_INC:  delay_d = (delay_q >= MAX_V) ? MAX_V : delay_q + WIDTH'(1);
            OP_DEC:  delay_d = (delay_q <= MIN_V) ? MIN_V : delay_q - WIDTH'(1);
            OP_SET: begin
               if (sel_val_s < MIN_V) begin
                  delay_d = MIN_V;
               end else if (sel_val_s > MAX_V) begin
                  delay_d = MAX_V;
               end else begin
                  delay_d = sel_val_s;
               end
            end
            default: delay_d = delay_q;
         endcase
      end else begin
         delay_d = delay_q;
      end
   end

   // Pause toggle, drop counter and registered read mux (reads see pre-write state)
   always_comb begin
      pause_d  = pause_q ^ key_pause ^ host_pause_s;
      drops_d  = drops_q + 8'(key_drop_s) + 8'(host_drop_s);
      status_s = 8'h00;
      status_s[STAT_KEY_PEND]   = key_pend_s;
      status_s[STAT_HOST_PEND]  = host_pend_s;
      status_s[STAT_LAST_GRANT] = last_grant_q;
      status_s[STAT_AT_MIN]     = at_min_s;
      status_s[STAT_AT_MAX]     = at_max_s;
      readdata_d = readdata_q;
      if (avs_read) begin
         case (avs_address)
            ADDR_DELAY:  readdata_d = 8'(delay_q);
            ADDR_CMD:    readdata_d = 8'h00;
            ADDR_STATUS: readdata_d = status_s;
            ADDR_DROPS:  readdata_d = drops_q;
            default:     readdata_d = 8'h00;
         endcase
      end else begin
         readdata_d = readdata_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         delay_q      <= INIT_V;
         pause_q      <= 1'b0;
         last_grant_q <= 1'b0;
         drops_q      <= 8'h00;
         readdata_q   <= 8'h00;
      end else begin
         delay_q      <= delay_d;
         pause_q      <= pause_d;
         last_grant_q <= last_grant_d;
         drops_q      <= drops_d;
         readdata_q   <= readdata_d;
      end
   end

   assign delay        = delay_q;
   assign pause        = pause_q;
   assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter with a cycle-level behavioural model and literal spot checks.
module tb_delay_arbiter;

   localparam int W    = 4;
   localparam int MN   = 0;
   localparam int MX   = 15;
   localparam int INIT = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         key_slower, key_faster, key_pause;
   logic [1:0]   avs_address;
   logic         avs_write, avs_read;
   logic [7:0]   avs_writedata, avs_readdata;
   logic [W-1:0] delay;
   logic         pause;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // model state: plain integers describing the visible behaviour
   int m_delay, m_pause, m_last, m_drops, m_rd;
   int m_kp, m_kop, m_hp, m_hop, m_hval;

   always #10 clk = ~clk;

   delay_arbiter #(.WIDTH(W), .DELAY_MIN(MN), .DELAY_MAX(MX), .DELAY_INIT(INIT)) dut (
      .clk           (clk),
      .reset         (reset),
      .key_slower    (key_slower),
      .key_faster    (key_faster),
      .key_pause     (key_pause),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .delay         (delay),
      .pause         (pause)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int apply_op(input int d, input int op, input int v);
      if (op == 0) return (d + 1 > MX) ? MX : d + 1;
      if (op == 1) return (d - 1 < MN) ? MN : d - 1;
      if (v < MN) return MN;
      if (v > MX) return MX;
      return v;
   endfunction

   // reference behaviour, advanced once per rising edge from the inputs held across it
   always @(posedge clk) begin : model
      int g, st;
      bit hs, hf, hset, hp_cmd;
      if (reset) begin
         m_delay = INIT; m_pause = 0; m_last = 0; m_drops = 0; m_rd = 0;
         m_kp = 0; m_kop = 0; m_hp = 0; m_hop = 0; m_hval = 0;
      end else begin
         st = m_kp + 2 * m_hp + 4 * m_last + 8 * int'(m_delay == MN) + 16 * int'(m_delay == MX);
         if (avs_read) begin
            case (avs_address)
               2'd0:    m_rd = m_delay;
               2'd2:    m_rd = st;
               2'd3:    m_rd = m_drops;
               default: m_rd = 0;
            endcase
         end
         g = 0;
         if (m_kp != 0 && m_hp != 0) g = (m_last != 0) ? 1 : 2;
         else if (m_kp != 0) g = 1;
         else if (m_hp != 0) g = 2;
         if (g == 1) begin
            m_delay = apply_op(m_delay, m_kop, 0); m_kp = 0; m_last = 0;
         end else if (g == 2) begin
            m_delay = apply_op(m_delay, m_hop, m_hval); m_hp = 0; m_last = 1;
         end
         if (key_slower != key_faster) begin
            if (m_kp != 0) m_drops = (m_drops + 1) % 256;
            m_kp = 1; m_kop = key_slower ? 0 : 1;
         end
         hset   = avs_write && avs_address == 2'd0;
         hp_cmd = avs_write && avs_address == 2'd1;
         hs     = hp_cmd && avs_writedata[0];
         hf     = hp_cmd && avs_writedata[1];
         if (hset || hs != hf) begin
            if (m_hp != 0) m_drops = (m_drops + 1) % 256;
            m_hp = 1;
            if (hset) begin
               m_hop = 2; m_hval = int'(avs_writedata) % 16;
            end else begin
               m_hop = hs ? 0 : 1;
            end
         end
         if (key_pause != (hp_cmd && avs_writedata[2])) m_pause = 1 - m_pause;
      end
   end

   // every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("delay_vs_model", delay, m_delay);
         check("pause_vs_model", pause, m_pause);
         check("readdata_vs_model", avs_readdata, m_rd);
      end
   end

   task automatic nxt(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr();
      key_slower = 1'b0; key_faster = 1'b0; key_pause = 1'b0;
      avs_write = 1'b0; avs_read = 1'b0; avs_writedata = 8'h00; avs_address = 2'd0;
   endtask

   task automatic hwrite(input logic [1:0] a, input logic [7:0] d);
      avs_write = 1'b1; avs_address = a; avs_writedata = d;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] v);
      avs_read = 1'b1; avs_address = a;
      nxt(1);
      avs_read = 1'b0;
      v = avs_readdata;
   endtask

   initial begin
      logic [7:0] v;
      clr();
      reset = 1'b1;
      nxt(3);
      reset = 1'b0;
      chk_en = 1'b1;

      rd(2'd0, v);
      check("init_delay_read", v, 8);
      check("init_pause", pause, 0);

      key_slower = 1'b1; nxt(1); key_slower = 1'b0;
      check("slot_latency", delay, 8);
      nxt(1);
      check("slower_once", delay, 9);

      repeat (10) begin
         key_slower = 1'b1; nxt(1); key_slower = 1'b0; nxt(2);
      end
      check("sat_max", delay, 15);
      rd(2'd2, v);
      check("status_at_max", v[4], 1);

      hwrite(2'd0, 8'd8); nxt(1); clr(); nxt(2);
      check("set_8", delay, 8);

      key_faster = 1'b1; hwrite(2'd1, 8'h01); nxt(1); clr(); nxt(1);
      check("key_first", delay, 7);
      nxt(1);
      check("host_next", delay, 8);
      rd(2'd2, v);
      check("last_grant_host", v[2], 1);

      key_slower = 1'b1; hwrite(2'd1, 8'h02); nxt(1);
      key_slower = 1'b0; nxt(1); clr(); nxt(2);
      check("one_dec_only", delay, 8);
      rd(2'd3, v);
      check("drops_one", v, 1);

      hwrite(2'd0, 8'h1F); nxt(1); clr(); nxt(2);
      check("set_clamp_max", delay, 15);
      key_slower = 1'b1; key_faster = 1'b1; nxt(1); clr();
      rd(2'd2, v);
      check("cancel_no_pending", v[0], 0);
      nxt(2);
      check("cancel_delay", delay, 15);

      hwrite(2'd0, 8'h00); nxt(1); clr(); nxt(2);
      key_faster = 1'b1; nxt(1); clr(); nxt(2);
      check("sat_min", delay, 0);
      rd(2'd2, v);
      check("status_at_min", v[3], 1);

      key_pause = 1'b1; hwrite(2'd1, 8'h04); nxt(1); clr();
      check("pause_xor", pause, 0);
      key_pause = 1'b1; nxt(1); clr();
      check("pause_toggle", pause, 1);

      key_slower = 1'b1; hwrite(2'd1, 8'h01); nxt(1); clr();
      reset = 1'b1; key_faster = 1'b1; nxt(1);
      reset = 1'b0; key_faster = 1'b0;
      check("reset_delay", delay, 8);
      check("reset_pause", pause, 0);
      rd(2'd2, v);
      check("reset_status", v, 0);
      rd(2'd3, v);
      check("reset_drops", v, 0);
      nxt(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
